dncnt_ld: RTL and testbench
===========================

Name: dncnt_ld

Overview:
Loadable down-counter/timer: the counterpart of the free-running up-counter used across the tutorial blocks.
- Loads a start value, decrements while enabled, and flags terminal count with a single-cycle done pulse.
- Used as a programmable delay/timeout generator by control FSMs.
- Sits between a controller (load/enable/clear) and whatever consumes the done pulse.

Parameters:
LDBND, 15, maximum legal load value; counter width W = $clog2(LDBND+1)

Ports:
i_clk  input  1  clock, rising-edge
i_rstn  input  1  reset, asynchronous, active-low
i_load  input  1  load strobe; samples i_ld_val
i_ld_val  input  W  start value for the count
i_en  input  1  count enable; decrement only when high
i_clr  input  1  synchronous abort/clear
o_cnt  output  W  current count value (registered)
o_busy  output  1  high while a count is in progress
o_done  output  1  one-cycle pulse at terminal count (registered)

Behaviour:
- Clock and reset: i_clk is the clock. i_rstn is the reset: asynchronous, active-low.
- Reset values: o_cnt=0, o_busy=0, o_done=0, state=IDLE, load-shadow register=0.
- States:
  - IDLE: o_busy=0.
  - RUN: o_busy=1.
  - o_busy is decoded directly from the state register.
- Priority per cycle: i_clr > i_load > decrement.
- i_clr (any state): next cycle o_cnt=0, o_done=0, state=IDLE. Any pending completion is discarded.
- Load clamping:
  - Loaded value V = min(i_ld_val, LDBND).
  - A value above LDBND saturates to LDBND; it does not wrap.
  - V is also stored in the load-shadow register.
- i_load with V>0 (IDLE or RUN): next cycle o_cnt=V, state=RUN, o_done=0. A load in RUN restarts the count.
- i_load with V=0: next cycle o_cnt=0, o_done=1 for one cycle, state=IDLE (immediate completion).
- Counting in RUN with i_en=1:
  - o_cnt>1: o_cnt decrements by 1.
  - o_cnt==1: terminal event. Next cycle o_cnt=0, o_done=1, state=IDLE (see optional feature).
- RUN with i_en=0: o_cnt holds; o_done=0.
- IDLE without i_load: o_cnt holds its value; i_en is ignored; no underflow below 0 ever occurs.
- o_done:
  - High for exactly one cycle per terminal event; the registered pulse coincides with the first cycle o_cnt shows the terminal value.
  - Low in every other cycle.
- Latency: load of V with i_en held high gives o_done high V cycles after the load edge.
- Simultaneous i_load and terminal event: the load wins. No o_done; the count restarts at the new V.
- Simultaneous i_clr and i_load: the clear wins.
- Asynchronous reset mid-count: all outputs return to reset values immediately. Nothing resumes after release.

Optional Feature:
Macro DNCNT_RELOAD_EN.
- Defined (auto-reload): at the terminal event o_cnt reloads the shadow value, state stays RUN, and o_busy stays 1. o_done still pulses one cycle per period. Periodic tick with period = shadow value. A shadow value of 0 is not reachable in RUN. i_clr is the only way back to IDLE other than reset.
- Undefined: one-shot behaviour as described above. The shadow register may be removed by synthesis.

Test Plan:
- Reset: assert i_rstn=0 mid-count (o_cnt=7) -> o_cnt=0, o_busy=0, o_done=0 immediately, and they hold after release with no strobes.
- One-shot: LDBND=10, i_load with i_ld_val=5, i_en=1 held -> o_cnt 5,4,3,2,1,0. o_done=1 only in the o_cnt=0 cycle, 5 cycles after load. o_busy falls the same cycle.
- Clamp and zero load: i_ld_val=15 (LDBND=10) -> o_cnt=10. i_ld_val=0 -> o_cnt=0, o_done one-cycle pulse next cycle, o_busy stays 0.
- Enable gating: load 3, i_en sequence 1,0,0,1,1 -> o_cnt 3,2,2,2,1,0. o_done only at final 0.
- Collisions: at o_cnt=1 assert i_load (value 4) with i_en=1 -> o_cnt=4, no o_done. At o_cnt=2 assert i_clr and i_load together -> o_cnt=0, IDLE, no o_done.
- DNCNT_RELOAD_EN defined: load 3, i_en=1 -> o_cnt 3,2,1,3,2,1,3... with o_done pulse at each 1->3 transition and o_busy constant 1. i_clr -> IDLE, o_cnt=0.

Source files
------------

// File: rtl/dncnt_ld_if.sv
// Controller-side bundle for the loadable down-counter: load/enable/clear strobes
// toward the counter and count/busy/done status back to the controller.
interface dncnt_ld_if #(
   parameter int W = 4
) ();
   logic         i_load;
   logic [W-1:0] i_ld_val;
   logic         i_en;
   logic         i_clr;
   logic [W-1:0] o_cnt;
   logic         o_busy;
   logic         o_done;

   modport master (
      output i_load, i_ld_val, i_en, i_clr,
      input  o_cnt, o_busy, o_done
   );

   modport slave (
      input  i_load, i_ld_val, i_en, i_clr,
      output o_cnt, o_busy, o_done
   );
endinterface

// File: rtl/dncnt_ld.sv
// Loadable down-counter/timer with a registered one-cycle done pulse at terminal count.
// Define DNCNT_RELOAD_EN to reload the last loaded value at terminal count (periodic tick).
module dncnt_ld #(
   parameter int LDBND = 15
) (
   input  logic        i_clk,
   input  logic        i_rstn,
   dncnt_ld_if.slave   bus
);
   localparam int W = $clog2(LDBND + 1);
   localparam logic [W-1:0] LDBND_W = W'(LDBND);
   localparam logic [W-1:0] CNT_ONE = W'(32'd1);
   localparam logic [W-1:0] CNT_ZERO = W'(32'd0);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t       state_q, state_d;
   logic [W-1:0] cnt_q, cnt_d;
   logic         done_q, done_d;
   logic [W-1:0] ld_v;
`ifdef DNCNT_RELOAD_EN
   logic [W-1:0] shadow_q, shadow_d;
`endif

   // Oversized load values saturate at the bound instead of wrapping.
   function automatic logic [W-1:0] clamp_ld(input logic [W-1:0] v);
      if (v > LDBND_W) begin
         clamp_ld = LDBND_W;
      end else begin
         clamp_ld = v;
      end
   endfunction

   assign ld_v = clamp_ld(bus.i_ld_val);

   // Next-state and next-output decode: clear beats load beats decrement.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      done_d   = 1'b0;
`ifdef DNCNT_RELOAD_EN
      shadow_d = shadow_q;
`endif
      if (bus.i_clr) begin
         state_d = IDLE;
         cnt_d   = CNT_ZERO;
      end else if (bus.i_load) begin
`ifdef DNCNT_RELOAD_EN
         shadow_d = ld_v;
`endif
         if (ld_v != CNT_ZERO) begin
            state_d = RUN;
            cnt_d   = ld_v;
         end else begin
            state_d = IDLE;
            cnt_d   = CNT_ZERO;
            done_d  = 1'b1;
         end
      end else begin
         case (state_q)
            IDLE: begin
               state_d = IDLE;
            end
            RUN: begin
               if (!bus.i_en) begin
                  cnt_d = cnt_q;
               end else if (cnt_q > CNT_ONE) begin
                  cnt_d = cnt_q - CNT_ONE;
               end else begin
                  done_d = 1'b1;
`ifdef DNCNT_RELOAD_EN
                  state_d = RUN;
                  cnt_d   = shadow_q;
`else
                  state_d = IDLE;
                  cnt_d   = CNT_ZERO;
`endif
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = CNT_ZERO;
            end
         endcase
      end
   end

   // State, count and done registers with asynchronous active-low reset.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_q <= IDLE;
         cnt_q   <= CNT_ZERO;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end

`ifdef DNCNT_RELOAD_EN
   // Shadow of the last clamped load value, used as the reload period.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         shadow_q <= CNT_ZERO;
      end else begin
         shadow_q <= shadow_d;
      end
   end
`endif

   assign bus.o_cnt  = cnt_q;
   assign bus.o_busy = (state_q == RUN);
   assign bus.o_done = done_q;
endmodule

// File: tb/tb_dncnt_ld.sv
// Randomized and directed bench for dncnt_ld against a behavioural timer model.
module tb_dncnt_ld;
   localparam int LDBND = 10;
   localparam int W = $clog2(LDBND + 1);

   logic clk;
   logic rstn;
   int   checks = 0;
   int   errors = 0;

   // Reference model state: remaining ticks, running flag, done flag, period.
   int   m_cnt = 0;
   bit   m_run = 1'b0;
   bit   m_done = 1'b0;
   int   m_period = 0;

   dncnt_ld_if #(.W(W)) bus ();

   dncnt_ld #(.LDBND(LDBND)) dut (
      .i_clk  (clk),
      .i_rstn (rstn),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_cnt = 0;
      m_run = 1'b0;
      m_done = 1'b0;
      m_period = 0;
   endtask

   task automatic model_step(input bit ld, input int v, input bit en, input bit clr);
      int lv;
      lv = (v > LDBND) ? LDBND : v;
      m_done = 1'b0;
      if (clr) begin
         m_cnt = 0;
         m_run = 1'b0;
      end else if (ld) begin
         m_period = lv;
         m_cnt = lv;
         m_run = (lv > 0);
         m_done = (lv == 0);
      end else if (m_run && en) begin
         if (m_cnt > 1) begin
            m_cnt = m_cnt - 1;
         end else begin
            m_done = 1'b1;
`ifdef DNCNT_RELOAD_EN
            m_cnt = m_period;
`else
            m_cnt = 0;
            m_run = 1'b0;
`endif
         end
      end
   endtask

   task automatic check_outputs(input string tag);
      chk({tag, "_cnt"},  int'(bus.o_cnt),  m_cnt);
      chk({tag, "_busy"}, int'(bus.o_busy), int'(m_run));
      chk({tag, "_done"}, int'(bus.o_done), int'(m_done));
   endtask

   // One clock: drive inputs, advance model at the edge, compare just after.
   task automatic cycle(input string tag, input bit ld, input int v, input bit en, input bit clr);
      bus.i_load   = ld;
      bus.i_ld_val = W'(v);
      bus.i_en     = en;
      bus.i_clr    = clr;
      @(posedge clk);
      model_step(ld, v, en, clr);
      #1;
      check_outputs(tag);
   endtask

   initial begin
      int lat;
      rstn = 1'b0;
      bus.i_load = 1'b0;
      bus.i_ld_val = '0;
      bus.i_en = 1'b0;
      bus.i_clr = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_outputs("por");
      rstn = 1'b1;

      // One-shot with latency measurement.
      cycle("os_ld", 1'b1, 5, 1'b1, 1'b0);
      lat = -1;
      for (int i = 0; i < 20; i++) begin
         cycle("os_run", 1'b0, 0, 1'b1, 1'b0);
         if (bus.o_done) begin
            lat = i + 1;
            break;
         end
      end
      chk("os_latency", lat, 5);
      repeat (3) cycle("os_idle", 1'b0, 0, 1'b1, 1'b0);

      // Clamp and zero load.
      cycle("clamp", 1'b1, 15, 1'b0, 1'b0);
      chk("clamp_val", int'(bus.o_cnt), LDBND);
      cycle("clr0", 1'b0, 0, 1'b0, 1'b1);
      cycle("zero_ld", 1'b1, 0, 1'b1, 1'b0);
      chk("zero_done", int'(bus.o_done), 1);
      cycle("zero_after", 1'b0, 0, 1'b1, 1'b0);

      // Enable gating: 1,0,0,1,1.
      cycle("gate_ld", 1'b1, 3, 1'b0, 1'b0);
      cycle("gate", 1'b0, 0, 1'b1, 1'b0);
      cycle("gate", 1'b0, 0, 1'b0, 1'b0);
      cycle("gate", 1'b0, 0, 1'b0, 1'b0);
      cycle("gate", 1'b0, 0, 1'b1, 1'b0);
      cycle("gate", 1'b0, 0, 1'b1, 1'b0);

      // Load colliding with terminal count, then clear colliding with load.
      cycle("coll_ld", 1'b1, 2, 1'b1, 1'b0);
      cycle("coll_dec", 1'b0, 0, 1'b1, 1'b0);
      cycle("coll_reld", 1'b1, 4, 1'b1, 1'b0);
      chk("coll_nodone", int'(bus.o_done), 0);
      cycle("coll_dec", 1'b0, 0, 1'b1, 1'b0);
      cycle("coll_dec", 1'b0, 0, 1'b1, 1'b0);
      cycle("clr_ld", 1'b1, 6, 1'b1, 1'b1);
      chk("clr_ld_cnt", int'(bus.o_cnt), 0);
      repeat (3) cycle("clr_idle", 1'b0, 0, 1'b1, 1'b0);

      // Periodic run (reload build) or one-shot then idle.
      cycle("per_ld", 1'b1, 3, 1'b1, 1'b0);
      repeat (10) cycle("per", 1'b0, 0, 1'b1, 1'b0);
      cycle("per_clr", 1'b0, 0, 1'b1, 1'b1);

      // Asynchronous reset mid-count at 7.
      cycle("ar_ld", 1'b1, 9, 1'b1, 1'b0);
      cycle("ar_dec", 1'b0, 0, 1'b1, 1'b0);
      cycle("ar_dec", 1'b0, 0, 1'b1, 1'b0);
      chk("ar_pre", int'(bus.o_cnt), 7);
      #2;
      rstn = 1'b0;
      #1;
      model_reset();
      check_outputs("ar_now");
      @(posedge clk);
      #1;
      rstn = 1'b1;
      repeat (4) cycle("ar_hold", 1'b0, 0, 1'b1, 1'b0);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         bit ld, en, clr;
         int v;
         ld  = ($urandom_range(0, 99) < 12);
         clr = ($urandom_range(0, 99) < 4);
         en  = ($urandom_range(0, 99) < 75);
         v   = $urandom_range(0, (1 << W) - 1);
         cycle("rnd", ld, v, en, clr);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
